// File: rtl/stage_if_prefetch_pkg.sv
// Shared constants and small types for the prefetching IF stage.
// Imported by the fetch queue and the stage top.
package stage_if_prefetch_pkg;

    localparam logic RESET_ENABLE  = 1'b0;
    localparam logic STALL_DISABLE = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam int   INSTR_STEP    = 4;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_DROP = 2'd1,
        RSP_FILL = 2'd2
    } rsp_action_e;

    function automatic int ptr_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stage_if_prefetch_fetch_queue.sv
// Prefetch queue: slots are reserved with a PC at issue time and
// filled in order as memory responses return.
module fetch_queue
    import stage_if_prefetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 4,
    localparam int PW = ptr_bits(QUEUE_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_reserve,
    input  logic [ADDR_WIDTH-1:0] i_reserve_pc,
    input  logic                  i_fill,
    input  logic [DATA_WIDTH-1:0] i_fill_data,
    input  logic                  i_pop,
    output logic                  o_head_valid,
    output logic [ADDR_WIDTH-1:0] o_head_pc,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic [PW-1:0]         o_occupancy
);

    localparam int IW = PW - 1;

    logic [PW-1:0]         r_alloc_ptr;
    logic [PW-1:0]         r_fill_ptr;
    logic [PW-1:0]         r_read_ptr;
    logic [ADDR_WIDTH-1:0] r_pc   [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] r_data [QUEUE_DEPTH];

    logic [IW-1:0] w_alloc_idx;
    logic [IW-1:0] w_fill_idx;
    logic [IW-1:0] w_read_idx;
    logic          w_do_reserve;
    logic          w_do_fill;
    logic          w_do_pop;

    assign w_alloc_idx = r_alloc_ptr[IW-1:0];
    assign w_fill_idx  = r_fill_ptr[IW-1:0];
    assign w_read_idx  = r_read_ptr[IW-1:0];

    assign w_do_reserve = (i_reserve == WRITE_ENABLE) && !i_flush;
    assign w_do_fill    = (i_fill == WRITE_ENABLE) && !i_flush;
    assign w_do_pop     = i_pop && o_head_valid && !i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (i_rst_n == RESET_ENABLE) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_read_ptr  <= '0;
        end else if (i_flush) begin
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_read_ptr  <= '0;
        end else begin
            if (w_do_reserve) begin
                r_alloc_ptr <= r_alloc_ptr + PW'(1);
            end
            if (w_do_fill) begin
                r_fill_ptr <= r_fill_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_read_ptr <= r_read_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (i_rst_n == RESET_ENABLE) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_pc[i]   <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_do_reserve) begin
                r_pc[w_alloc_idx] <= i_reserve_pc;
            end
            if (w_do_fill) begin
                r_data[w_fill_idx] <= i_fill_data;
            end
        end
    end

    // Only filled entries count; reserved slots are tracked by the
    // caller's in-flight counter.
    assign o_occupancy  = r_fill_ptr - r_read_ptr;
    assign o_head_valid = (r_fill_ptr != r_read_ptr);
    assign o_head_pc    = r_pc[w_read_idx];
    assign o_head_data  = r_data[w_read_idx];

endmodule

// File: rtl/stage_if_prefetch.sv
// IF stage: owns the fetch PC, issues in-order imem requests and
// feeds ID from a prefetch queue; redirect flushes and drops stale data.
module stage_if_prefetch
    import stage_if_prefetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    QUEUE_DEPTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [5:0]            stall,
    input  logic                  redirect_enable,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_request_valid,
    input  logic                  imem_request_ready,
    output logic [ADDR_WIDTH-1:0] imem_request_address,
    input  logic                  imem_response_valid,
    input  logic [DATA_WIDTH-1:0] imem_response_data,
    output logic                  instruction_valid,
    input  logic                  instruction_ready,
    output logic [ADDR_WIDTH-1:0] instruction_pc,
    output logic [DATA_WIDTH-1:0] instruction_data
);

    localparam int PW = ptr_bits(QUEUE_DEPTH);
    localparam int SW = PW + 2;

    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [PW-1:0]         r_in_flight;
    logic [PW-1:0]         r_drop;

    logic [PW-1:0]   w_occupancy;
    logic [SW-1:0]   w_used;
    logic            w_room;
    logic            w_req_valid;
    logic            w_accept;
    logic            w_fill;
    logic            w_head_valid;
    rsp_action_e     w_rsp;
    logic            w_unused;

    assign w_unused = ^{stall[5:1], redirect_pc[1:0]};

    assign w_used = SW'(w_occupancy) + SW'(r_in_flight) + SW'(r_drop);
    assign w_room = (w_used < SW'(QUEUE_DEPTH));

    assign w_req_valid = (reset != RESET_ENABLE)
                       && !redirect_enable
                       && (stall[0] == STALL_DISABLE)
                       && w_room;
    assign w_accept = w_req_valid && imem_request_ready;

    // Pending drops are owed to the oldest responses, so they go first.
    always_comb begin
        w_rsp = RSP_NONE;
        if (imem_response_valid) begin
            if (r_drop != '0) begin
                w_rsp = RSP_DROP;
            end else if (r_in_flight != '0) begin
                w_rsp = RSP_FILL;
            end
        end
    end

    assign w_fill = (w_rsp == RSP_FILL) && !redirect_enable;

    always_ff @(posedge clock or negedge reset) begin
        if (reset == RESET_ENABLE) begin
            r_fetch_pc  <= RESET_VECTOR;
            r_in_flight <= '0;
            r_drop      <= '0;
        end else if (redirect_enable) begin
            r_fetch_pc  <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            r_in_flight <= '0;
            r_drop      <= r_drop + r_in_flight
                         - PW'(imem_response_valid);
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(INSTR_STEP);
            end
            r_in_flight <= r_in_flight + PW'(w_accept)
                         - PW'(w_rsp == RSP_FILL);
            if (w_rsp == RSP_DROP) begin
                r_drop <= r_drop - PW'(1);
            end
        end
    end

    fetch_queue #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .i_clk        (clock),
        .i_rst_n      (reset),
        .i_flush      (redirect_enable),
        .i_reserve    (w_accept),
        .i_reserve_pc (r_fetch_pc),
        .i_fill       (w_fill),
        .i_fill_data  (imem_response_data),
        .i_pop        (instruction_ready),
        .o_head_valid (w_head_valid),
        .o_head_pc    (instruction_pc),
        .o_head_data  (instruction_data),
        .o_occupancy  (w_occupancy)
    );

    assign imem_request_valid   = w_req_valid;
    assign imem_request_address = r_fetch_pc;
    assign instruction_valid    = w_head_valid && (reset != RESET_ENABLE);

endmodule

// File: tb/tb_stage_if_prefetch.sv
// Directed bench for stage_if_prefetch with a queued memory model.
// Reset vector near the top of memory so the PC wrap is exercised.
module tb_stage_if_prefetch;

    localparam logic [31:0] RV = 32'hFFFF_FFF8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  stall = 6'd0;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = 32'd0;
    logic        req_v;
    logic        req_rdy = 1'b0;
    logic [31:0] req_a;
    logic        rsp_v = 1'b0;
    logic [31:0] rsp_d = 32'd0;
    logic        iv;
    logic        ins_rdy = 1'b0;
    logic [31:0] ipc;
    logic [31:0] idata;

    int total = 0;
    int bad = 0;
    int n_acc = 0;
    int base;
    logic mem_hold = 1'b0;
    logic [31:0] mq[$];

    always #5 clock = ~clock;

    stage_if_prefetch #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .RESET_VECTOR (RV),
        .QUEUE_DEPTH  (4)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .stall                (stall),
        .redirect_enable      (redir),
        .redirect_pc          (redir_pc),
        .imem_request_valid   (req_v),
        .imem_request_ready   (req_rdy),
        .imem_request_address (req_a),
        .imem_response_valid  (rsp_v),
        .imem_response_data   (rsp_d),
        .instruction_valid    (iv),
        .instruction_ready    (ins_rdy),
        .instruction_pc       (ipc),
        .instruction_data     (idata)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a ^ 32'hA5A5_0000) + 32'h0000_0013;
    endfunction

    // In-order memory: one response per accept, earliest next cycle.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.delete();
            rsp_v <= 1'b0;
            rsp_d <= 32'd0;
        end else begin
            if (req_v && req_rdy) begin
                mq.push_back(req_a);
                n_acc++;
            end
            if (!mem_hold && mq.size() > 0) begin
                rsp_v <= 1'b1;
                rsp_d <= mem_word(mq.pop_front());
            end else begin
                rsp_v <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    typedef struct {
        logic        rdy;
        logic        idr;
        logic        rv;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] ipc;
    } vec_t;

    function automatic vec_t mk(input logic rdy, input logic idr,
                                input logic rv, input logic [31:0] a,
                                input logic v, input logic [31:0] p);
        vec_t t;
        t.rdy = rdy; t.idr = idr; t.rv = rv;
        t.addr = a; t.iv = v; t.ipc = p;
        return t;
    endfunction

    vec_t tbl[10];
    logic found;

    initial begin
        tbl[0] = mk(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
        tbl[1] = mk(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
        tbl[2] = mk(1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFF8);
        tbl[3] = mk(1'b1, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC);
        tbl[4] = mk(1'b0, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000);
        tbl[5] = mk(1'b0, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004);
        tbl[6] = mk(1'b0, 1'b1, 1'b1, 32'h0000_0008, 1'b0, 32'h0);
        tbl[7] = mk(1'b1, 1'b1, 1'b1, 32'h0000_0008, 1'b0, 32'h0);
        tbl[8] = mk(1'b1, 1'b1, 1'b1, 32'h0000_000C, 1'b0, 32'h0);
        tbl[9] = mk(1'b1, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_0008);

        repeat (2) step();
        req_rdy = 1'b1;
        #1;
        chk("rst_req_valid", 32'(req_v), 32'd0);
        chk("rst_ins_valid", 32'(iv), 32'd0);
        chk("rst_addr", req_a, RV);
        step();
        reset = 1'b1;

        // basic streaming, address wrap, request held while not ready
        for (int i = 0; i < 10; i++) begin
            req_rdy = tbl[i].rdy;
            ins_rdy = tbl[i].idr;
            #1;
            chk($sformatf("v%0d_req_valid", i), 32'(req_v), 32'(tbl[i].rv));
            chk($sformatf("v%0d_addr", i), req_a, tbl[i].addr);
            chk($sformatf("v%0d_ins_valid", i), 32'(iv), 32'(tbl[i].iv));
            if (tbl[i].iv) begin
                chk($sformatf("v%0d_ins_pc", i), ipc, tbl[i].ipc);
                chk($sformatf("v%0d_ins_data", i), idata, mem_word(tbl[i].ipc));
            end
            step();
        end

        // queue fills to depth with ID blocked
        req_rdy = 1'b0;
        ins_rdy = 1'b1;
        repeat (4) step();
        #1;
        chk("t3_drained_iv", 32'(iv), 32'd0);
        chk("t3_drained_addr", req_a, 32'h14);
        ins_rdy = 1'b0;
        req_rdy = 1'b1;
        base = n_acc;
        repeat (10) step();
        #1;
        chk("t3_fill_count", 32'(n_acc - base), 32'd4);
        chk("t3_full_req_valid", 32'(req_v), 32'd0);
        chk("t3_full_addr", req_a, 32'h24);
        chk("t3_head_pc", ipc, 32'h14);
        chk("t3_head_data", idata, mem_word(32'h14));
        ins_rdy = 1'b1;
        base = n_acc;
        step();
        ins_rdy = 1'b0;
        repeat (5) step();
        #1;
        chk("t3_pop_count", 32'(n_acc - base), 32'd1);
        chk("t3_pop_head_pc", ipc, 32'h18);
        chk("t3_pop_addr", req_a, 32'h28);

        // redirect with two requests in flight
        mem_hold = 1'b1;
        req_rdy = 1'b0;
        redir = 1'b1;
        redir_pc = 32'h100;
        #1;
        chk("t4_redir_withdraw", 32'(req_v), 32'd0);
        step();
        redir = 1'b0;
        req_rdy = 1'b1;
        #1;
        chk("t4_flush_iv", 32'(iv), 32'd0);
        chk("t4_addr_100", req_a, 32'h100);
        step();
        step();
        req_rdy = 1'b0;
        #1;
        chk("t4_addr_108", req_a, 32'h108);
        redir = 1'b1;
        redir_pc = 32'h1003;
        step();
        redir = 1'b0;
        mem_hold = 1'b0;
        req_rdy = 1'b1;
        #1;
        chk("t4_addr_1000", req_a, 32'h1000);
        chk("t4_req_valid", 32'(req_v), 32'd1);
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            step();
            #1;
            if (iv) begin
                found = 1'b1;
                chk("t4_first_pc", ipc, 32'h1000);
                chk("t4_first_data", idata, mem_word(32'h1000));
            end
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL t4_first_instr: got none want pc 00001000");
        end

        // stall blocks issue only
        redir = 1'b1;
        redir_pc = 32'h200;
        ins_rdy = 1'b1;
        step();
        redir = 1'b0;
        req_rdy = 1'b0;
        repeat (8) step();
        #1;
        chk("t5_idle_iv", 32'(iv), 32'd0);
        chk("t5_addr_200", req_a, 32'h200);
        mem_hold = 1'b1;
        req_rdy = 1'b1;
        ins_rdy = 1'b0;
        step();
        step();
        stall = 6'h01;
        mem_hold = 1'b0;
        base = n_acc;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("t5_stall_rv%0d", k), 32'(req_v), 32'd0);
            step();
        end
        #1;
        chk("t5_stall_count", 32'(n_acc - base), 32'd0);
        chk("t5_stall_iv", 32'(iv), 32'd1);
        chk("t5_stall_pc", ipc, 32'h200);
        ins_rdy = 1'b1;
        step();
        ins_rdy = 1'b0;
        #1;
        chk("t5_pop_pc", ipc, 32'h204);
        redir = 1'b1;
        redir_pc = 32'h300;
        step();
        redir = 1'b0;
        #1;
        chk("t5_redir_addr", req_a, 32'h300);
        chk("t5_redir_rv", 32'(req_v), 32'd0);
        chk("t5_redir_iv", 32'(iv), 32'd0);
        stall = 6'h00;
        #1;
        chk("t5_resume_rv", 32'(req_v), 32'd1);
        step();

        // asynchronous reset mid-burst
        step();
        step();
        #1;
        chk("t6_pre_iv", 32'(iv), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_rst_rv", 32'(req_v), 32'd0);
        chk("t6_rst_iv", 32'(iv), 32'd0);
        chk("t6_rst_addr", req_a, RV);
        step();
        reset = 1'b1;
        #1;
        chk("t6_rel_addr", req_a, RV);
        chk("t6_rel_rv", 32'(req_v), 32'd1);
        chk("t6_rel_iv", 32'(iv), 32'd0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
